hcu_nway: RTL and testbench
===========================

Name: hcu_nway

Overview:
- Parametrised successor of the two-lane hazard control unit, for an N-lane in-order superscalar pipeline: S0 DECODE, S1 REGFILE, S2 EXEC, S3 MEMWRT, S4 REGWRT.
- Detects two kinds of hazard at S1:
  - load-use against an internal in-flight load scoreboard;
  - intra-group dependence between lanes.
- Issues S1 groups partially over several cycles, tracked by an issued-lane mask.
- Drives per-lane S1 update enables, per-lane/per-stage bubble resets, and the fetch/decode hold.

Parameters:
- LANES, 2, number of issue lanes; lane 0 is the oldest in a group.
- AW, 5, register-address width.
- LD_LAT, 2, stages a load spends after S2 before its data is forwardable. 2 means data is forwardable from S4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s1_valid  in  LANES  lane holds a real instruction in S1
- s1_rs1, s1_rs2  in  LANES*AW  source registers; lane l at [l*AW +: AW]
- s1_rd  in  LANES*AW  destination register
- s1_wr  in  LANES  lane writes s1_rd
- s1_ld  in  LANES  lane is a load
- s1_st  in  LANES  lane is a store
- flush  in  1  branch redirect; S1 and S2 contents are discarded
- upd1_out  out  LANES  lane's S1 register loads from S0
- rst_out  out  LANES*4  bubble reset; bit l*4+(s-1) clears lane l stage s. Bits for S3/S4 are always 0.
- fetch_en_out  out  1  0 holds PC and S0
- stalled_out  out  1  registered; 1 in the cycle after any cycle with fetch_en_out=0
- ld_stall_cnt_out, split_cnt_out  out  32 each  performance counters

Behaviour:
- State registers, all cleared by rst:
  - issued_q[LANES]: lanes of the current S1 group already sent to S2.
  - sb_v/sb_rd: scoreboard of load destinations for stages 2..1+LD_LAT.
  - stalled_out.
- Pending lanes: P = s1_valid & ~issued_q.
- Load hazard on lane l: l in P, and s1_rs1 or s1_rs2 equals a valid scoreboard sb_rd.
- Split point j: smallest pending lane for which an older pending lane i<j exists with either:
  - s1_wr[i] and rd[i] matching rs1[j] or rs2[j]; or
  - s1_ld[i] and s1_st[j].
- If no such lane exists, j = LANES.
- Decisions are combinational in the same cycle. Priority order:
  1. flush:
     - upd1_out all 1, fetch_en_out 1;
     - rst_out S1 and S2 bits set for all lanes;
     - issued_q and the scoreboard stage-2 entry cleared next cycle.
  2. Any load hazard (full stall):
     - fetch_en_out 0, upd1_out 0;
     - S2 bits set for all lanes (bubble);
     - issued_q unchanged; scoreboard shifts, with stage-2 entry invalid.
  3. j < LANES (split):
     - fetch_en_out 0, upd1_out 0;
     - lanes in P below j issue;
     - S2 bubble on lanes ≥ j and on lanes in issued_q;
     - issued_q |= issuing lanes; scoreboard shifts in the issuing loads.
  4. Otherwise (group completes):
     - all of P issues; upd1_out all 1, fetch_en_out 1;
     - S2 bubble on lanes in issued_q;
     - issued_q cleared; scoreboard shifts in the loads of P.
- Rule: a lane in issued_q always gets its S1 bit set whenever upd1_out is 0. No instruction executes twice.
- Scoreboard: 1+LD_LAT-1 shift stages; the oldest entry drops out every cycle, including during stalls.
- Latency: a load-use stall lasts at most LD_LAT cycles. A group needs at most LANES issue cycles.
- Reset mid-split: issued_q cleared; the pipeline is reset externally.
- s1_valid=0 lanes never cause hazards and are never recorded.

Optional Feature:
- HCU_PERF_EN:
  - defined: ld_stall_cnt_out counts full-stall cycles and split_cnt_out counts split cycles. Both wrap at 2^32 and clear on rst.
  - undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package hcu_pkg holds:
  - typedef sb_entry_t {v, rd};
  - constants HCU_STAGES=4 and bit-index function rst_idx(lane, stage).
- One sub-module, hcu_dep_cmp: compares one consumer lane (rs1, rs2, st) against one producer lane (rd, wr, ld). It outputs raw and st_after_ld, and is instantiated for every lane pair i<j.

Test Plan:
- LANES=2, lane0 `ADD r3`, lane1 reads r3:
  - cycle 0: upd1_out=00, rst_out lane0 S1 / lane1 S2 set, fetch_en_out=0;
  - cycle 1: group completes, stalled_out=1.
- Lane0 `LDR r4`, next group lane1 reads r4:
  - split, then 2 full-stall cycles with all S2 bits set;
  - third cycle issues; ld_stall_cnt_out=2.
- Lane0 `LDR r5`, lane1 `STR r6` in the same group: split as in case 0; split_cnt_out=1.
- LANES=4, each lane depends on the previous: 4 issue cycles; issued_q goes 0001→0011→0111→0000.
- flush during a split with issued_q=0011: next cycle issued_q=0000, the stage-2 scoreboard entry is invalid, and no stall occurs.
- rst asserted during a full stall: all outputs return to reset values the next cycle, with fetch_en_out=1 and stalled_out=0.

Source files
------------

// File: rtl/hcu_pkg.sv
// Shared types and helpers for the N-lane hazard control unit.
package hcu_pkg;

    localparam int HCU_STAGES = 4;
    // Widest register address the scoreboard can hold; AW must not exceed it.
    localparam int HCU_AW_MAX = 8;

    typedef struct packed {
        logic                  v;
        logic [HCU_AW_MAX-1:0] rd;
    } sb_entry_t;

    // Bit position in rst_out for a lane and a stage (stage 1..4).
    function automatic int rst_idx(input int lane, input int stage);
        return lane * HCU_STAGES + stage - 1;
    endfunction

endpackage

// File: rtl/hcu_dep_cmp.sv
// Pairwise dependence check of one consumer lane against one older producer lane.
module hcu_dep_cmp
    import hcu_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic          st,
    input  logic [AW-1:0] rd,
    input  logic          wr,
    input  logic          ld,
    output logic          raw,
    output logic          st_after_ld
);

    assign raw         = wr && ((rd == rs1) || (rd == rs2));
    // A store may not share an issue cycle with an older load.
    assign st_after_ld = ld && st;

endmodule

// File: rtl/hcu_nway.sv
// N-lane hazard control unit: load-use stalls, intra-group splits, bubble resets.
// Optional performance counters are built when HCU_PERF_EN is defined.
module hcu_nway
    import hcu_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int AW     = 5,
    parameter int LD_LAT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LANES-1:0]             s1_valid,
    input  logic [LANES*AW-1:0]          s1_rs1,
    input  logic [LANES*AW-1:0]          s1_rs2,
    input  logic [LANES*AW-1:0]          s1_rd,
    input  logic [LANES-1:0]             s1_wr,
    input  logic [LANES-1:0]             s1_ld,
    input  logic [LANES-1:0]             s1_st,
    input  logic                         flush,
    output logic [LANES-1:0]             upd1_out,
    output logic [LANES*HCU_STAGES-1:0]  rst_out,
    output logic                         fetch_en_out,
    output logic                         stalled_out,
    output logic [31:0]                  ld_stall_cnt_out,
    output logic [31:0]                  split_cnt_out
);

    logic [LANES-1:0]       issued_q, issued_d;
    logic [LANES-1:0]       pend, ld_haz, hit, below, issue;
    logic [LANES-1:0]       s1_clr, s2_clr;
    logic [LANES*LANES-1:0] raw_w, sal_w;
    logic                   stalled_q;
    sb_entry_t              sb_q [LD_LAT][LANES];
    sb_entry_t              sb_d [LD_LAT][LANES];

    assign pend = s1_valid & ~issued_q;

    // Pair matrix, entry j*LANES+i: consumer lane j against older producer lane i.
    for (genvar gj = 0; gj < LANES; gj++) begin : g_cons
        for (genvar gi = 0; gi < LANES; gi++) begin : g_prod
            if (gi < gj) begin : g_cmp
                hcu_dep_cmp #(.AW(AW)) u_cmp (
                    .rs1         (s1_rs1[gj*AW +: AW]),
                    .rs2         (s1_rs2[gj*AW +: AW]),
                    .st          (s1_st[gj]),
                    .rd          (s1_rd[gi*AW +: AW]),
                    .wr          (s1_wr[gi]),
                    .ld          (s1_ld[gi]),
                    .raw         (raw_w[gj*LANES+gi]),
                    .st_after_ld (sal_w[gj*LANES+gi])
                );
            end else begin : g_none
                assign raw_w[gj*LANES+gi] = 1'b0;
                assign sal_w[gj*LANES+gi] = 1'b0;
            end
        end
    end

    always_comb begin
        ld_haz = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < LD_LAT; k++) begin
                for (int m = 0; m < LANES; m++) begin
                    if (pend[l] && sb_q[k][m].v &&
                        ((sb_q[k][m].rd == HCU_AW_MAX'(s1_rs1[l*AW +: AW])) ||
                         (sb_q[k][m].rd == HCU_AW_MAX'(s1_rs2[l*AW +: AW]))))
                        ld_haz[l] = 1'b1;
                end
            end
        end
    end

    // below marks lanes strictly older than the first conflicting pending lane.
    always_comb begin
        logic acc;
        hit   = '0;
        below = '0;
        acc   = 1'b1;
        for (int j = 0; j < LANES; j++) begin
            for (int i = 0; i < LANES; i++) begin
                if (i < j && pend[i] && pend[j] &&
                    (raw_w[j*LANES+i] || sal_w[j*LANES+i]))
                    hit[j] = 1'b1;
            end
        end
        for (int l = 0; l < LANES; l++) begin
            acc      = acc & ~hit[l];
            below[l] = acc;
        end
    end

    always_comb begin
        upd1_out     = '1;
        fetch_en_out = 1'b1;
        issue        = '0;
        issued_d     = issued_q;
        s1_clr       = '0;
        s2_clr       = '0;
        if (flush) begin
            s1_clr   = '1;
            s2_clr   = '1;
            issued_d = '0;
        end else if (|ld_haz) begin
            upd1_out     = '0;
            fetch_en_out = 1'b0;
            s1_clr       = issued_q;
            s2_clr       = '1;
        end else if (|hit) begin
            upd1_out     = '0;
            fetch_en_out = 1'b0;
            issue        = pend & below;
            s1_clr       = issued_q | issue;
            s2_clr       = ~below | issued_q;
            issued_d     = issued_q | issue;
        end else begin
            issue    = pend;
            s2_clr   = issued_q;
            issued_d = '0;
        end
    end

    always_comb begin
        rst_out = '0;
        for (int l = 0; l < LANES; l++) begin
            rst_out[rst_idx(l, 1)] = s1_clr[l];
            rst_out[rst_idx(l, 2)] = s2_clr[l];
        end
    end

    // A flush also discards the load that was sitting in S2.
    always_comb begin
        for (int m = 0; m < LANES; m++) begin
            sb_d[0][m].v  = issue[m] & s1_ld[m];
            sb_d[0][m].rd = HCU_AW_MAX'(s1_rd[m*AW +: AW]);
        end
        for (int k = 1; k < LD_LAT; k++) begin
            for (int m = 0; m < LANES; m++) begin
                sb_d[k][m] = sb_q[k-1][m];
                if (flush && k == 1)
                    sb_d[k][m].v = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q  <= '0;
            stalled_q <= 1'b0;
            for (int k = 0; k < LD_LAT; k++)
                for (int m = 0; m < LANES; m++)
                    sb_q[k][m] <= '0;
        end else begin
            issued_q  <= issued_d;
            stalled_q <= ~fetch_en_out;
            sb_q      <= sb_d;
        end
    end

    assign stalled_out = stalled_q;

`ifdef HCU_PERF_EN
    logic [31:0] ld_cnt_q, split_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_cnt_q    <= '0;
            split_cnt_q <= '0;
        end else begin
            if (!flush && (|ld_haz))
                ld_cnt_q <= ld_cnt_q + 32'd1;
            if (!flush && !(|ld_haz) && (|hit))
                split_cnt_q <= split_cnt_q + 32'd1;
        end
    end

    assign ld_stall_cnt_out = ld_cnt_q;
    assign split_cnt_out    = split_cnt_q;
`else
    assign ld_stall_cnt_out = '0;
    assign split_cnt_out    = '0;
`endif

endmodule

// File: tb/tb_hcu_nway.sv
// Scoreboard bench for hcu_nway with a 2-lane and a 4-lane instance.
module tb_hcu_nway;

`ifdef HCU_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [1:0]  v2, wr2, ld2, st2;
    logic [9:0]  rs1_2, rs2_2, rd2;
    logic        fl2;
    logic [1:0]  upd2;
    logic [7:0]  ro2;
    logic        fe2, sto2;
    logic [31:0] ldc2, spc2;

    logic [3:0]  v4, wr4, ld4, st4;
    logic [19:0] rs1_4, rs2_4, rd4;
    logic        fl4;
    logic [3:0]  upd4;
    logic [15:0] ro4;
    logic        fe4, sto4;
    logic [31:0] ldc4, spc4;

    hcu_nway #(.LANES(2), .AW(5), .LD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .s1_valid(v2), .s1_rs1(rs1_2), .s1_rs2(rs2_2),
        .s1_rd(rd2), .s1_wr(wr2), .s1_ld(ld2), .s1_st(st2), .flush(fl2),
        .upd1_out(upd2), .rst_out(ro2), .fetch_en_out(fe2), .stalled_out(sto2),
        .ld_stall_cnt_out(ldc2), .split_cnt_out(spc2)
    );

    hcu_nway #(.LANES(4), .AW(5), .LD_LAT(2)) u_dut4 (
        .clk(clk), .rst(rst), .s1_valid(v4), .s1_rs1(rs1_4), .s1_rs2(rs2_4),
        .s1_rd(rd4), .s1_wr(wr4), .s1_ld(ld4), .s1_st(st4), .flush(fl4),
        .upd1_out(upd4), .rst_out(ro4), .fetch_en_out(fe4), .stalled_out(sto4),
        .ld_stall_cnt_out(ldc4), .split_cnt_out(spc4)
    );

    typedef struct {
        int          id;
        int          dut;
        logic [3:0]  upd;
        logic [15:0] ro;
        logic        fe;
        logic        st;
        logic [31:0] ldc;
        logic [31:0] spc;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Monitor: outputs are settled mid-cycle, so compare on the falling edge.
    initial begin
        exp_t        e;
        logic [3:0]  a_upd;
        logic [15:0] a_ro;
        logic        a_fe, a_st;
        logic [31:0] a_ldc, a_spc;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.dut == 2) begin
                    a_upd = {2'b00, upd2}; a_ro = {8'h00, ro2};
                    a_fe = fe2; a_st = sto2; a_ldc = ldc2; a_spc = spc2;
                end else begin
                    a_upd = upd4; a_ro = ro4;
                    a_fe = fe4; a_st = sto4; a_ldc = ldc4; a_spc = spc4;
                end
                n_tests++;
                if (a_upd !== e.upd || a_ro !== e.ro || a_fe !== e.fe ||
                    a_st !== e.st || a_ldc !== e.ldc || a_spc !== e.spc) begin
                    n_fail++;
                    $display("FAIL step%0d lanes=%0d: got upd1=%b rst_out=%h fetch_en=%b stalled=%b ldcnt=%0d splitcnt=%0d; want upd1=%b rst_out=%h fetch_en=%b stalled=%b ldcnt=%0d splitcnt=%0d",
                             e.id, e.dut, a_upd, a_ro, a_fe, a_st, a_ldc, a_spc,
                             e.upd, e.ro, e.fe, e.st, e.ldc, e.spc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int id, input int dut, input logic [3:0] upd,
                        input logic [15:0] ro, input logic fe, input logic st,
                        input int ldc, input int spc);
        exp_t e;
        e.id  = id;
        e.dut = dut;
        e.upd = upd;
        e.ro  = ro;
        e.fe  = fe;
        e.st  = st;
        e.ldc = PERF ? 32'(ldc) : 32'd0;
        e.spc = PERF ? 32'(spc) : 32'd0;
        sbq.push_back(e);
        tick();
    endtask

    task automatic idle();
        v2 = '0; wr2 = '0; ld2 = '0; st2 = '0; rs1_2 = '0; rs2_2 = '0; rd2 = '0; fl2 = 1'b0;
        v4 = '0; wr4 = '0; ld4 = '0; st4 = '0; rs1_4 = '0; rs2_4 = '0; rd4 = '0; fl4 = 1'b0;
    endtask

    task automatic set2(input int l, input bit v, input int a, input int b,
                        input int d, input bit w, input bit ld, input bit st);
        v2[l] = v; wr2[l] = w; ld2[l] = ld; st2[l] = st;
        rs1_2[l*5 +: 5] = 5'(a);
        rs2_2[l*5 +: 5] = 5'(b);
        rd2[l*5 +: 5]   = 5'(d);
    endtask

    task automatic set4(input int l, input bit v, input int a, input int b,
                        input int d, input bit w, input bit ld, input bit st);
        v4[l] = v; wr4[l] = w; ld4[l] = ld; st4[l] = st;
        rs1_4[l*5 +: 5] = 5'(a);
        rs2_4[l*5 +: 5] = 5'(b);
        rd4[l*5 +: 5]   = 5'(d);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle();
        tick();

        // Reset state, then ADD r3 followed by a reader of r3 in the same group.
        do_reset();
        step(0, 2, 4'b0011, 16'h0000, 1'b1, 1'b0, 0, 0);
        set2(0, 1, 1, 2, 3, 1, 0, 0);
        set2(1, 1, 3, 4, 7, 1, 0, 0);
        step(1, 2, 4'b0000, 16'h0021, 1'b0, 1'b0, 0, 0);
        step(2, 2, 4'b0011, 16'h0002, 1'b1, 1'b1, 0, 1);
        idle();
        step(3, 2, 4'b0011, 16'h0000, 1'b1, 1'b0, 0, 1);

        // Invalid producer lane never causes a split.
        do_reset();
        set2(0, 0, 1, 2, 3, 1, 0, 0);
        set2(1, 1, 3, 4, 7, 1, 0, 0);
        step(4, 2, 4'b0011, 16'h0000, 1'b1, 1'b0, 0, 0);
        // Store after a non-load with no register overlap: single cycle.
        set2(0, 1, 1, 2, 5, 1, 0, 0);
        set2(1, 1, 1, 6, 0, 0, 0, 1);
        step(5, 2, 4'b0011, 16'h0000, 1'b1, 1'b0, 0, 0);

        // LDR r4 then a reader of r4: split, two load-use stalls, issue.
        do_reset();
        set2(0, 1, 1, 2, 4, 1, 1, 0);
        set2(1, 1, 4, 5, 6, 1, 0, 0);
        step(6, 2, 4'b0000, 16'h0021, 1'b0, 1'b0, 0, 0);
        step(7, 2, 4'b0000, 16'h0023, 1'b0, 1'b1, 0, 1);
        step(8, 2, 4'b0000, 16'h0023, 1'b0, 1'b1, 1, 1);
        step(9, 2, 4'b0011, 16'h0002, 1'b1, 1'b1, 2, 1);

        // LDR r5 and STR r6 in one group split.
        do_reset();
        set2(0, 1, 1, 2, 5, 1, 1, 0);
        set2(1, 1, 1, 6, 0, 0, 0, 1);
        step(10, 2, 4'b0000, 16'h0021, 1'b0, 1'b0, 0, 0);
        step(11, 2, 4'b0011, 16'h0002, 1'b1, 1'b1, 0, 1);

        // Four-lane dependence chain issues one lane per cycle.
        do_reset();
        set4(0, 1, 2, 1, 8, 1, 0, 0);
        set4(1, 1, 8, 1, 9, 1, 0, 0);
        set4(2, 1, 9, 1, 10, 1, 0, 0);
        set4(3, 1, 10, 1, 11, 1, 0, 0);
        step(12, 4, 4'b0000, 16'h2221, 1'b0, 1'b0, 0, 0);
        step(13, 4, 4'b0000, 16'h2213, 1'b0, 1'b1, 0, 1);
        step(14, 4, 4'b0000, 16'h2133, 1'b0, 1'b1, 0, 2);
        step(15, 4, 4'b1111, 16'h0222, 1'b1, 1'b1, 0, 3);
        idle();
        step(16, 4, 4'b1111, 16'h0000, 1'b1, 1'b0, 0, 3);

        // Flush with issued lanes 0 and 1 (lane 1 a load of r9); r9 reader must not stall.
        do_reset();
        set4(0, 1, 2, 1, 8, 1, 0, 0);
        set4(1, 1, 8, 1, 9, 1, 1, 0);
        set4(2, 1, 9, 1, 10, 1, 0, 0);
        set4(3, 1, 10, 1, 11, 1, 0, 0);
        step(17, 4, 4'b0000, 16'h2221, 1'b0, 1'b0, 0, 0);
        step(18, 4, 4'b0000, 16'h2213, 1'b0, 1'b1, 0, 1);
        fl4 = 1'b1;
        step(19, 4, 4'b1111, 16'h3333, 1'b1, 1'b1, 0, 2);
        idle();
        set4(0, 1, 9, 1, 12, 1, 0, 0);
        step(20, 4, 4'b1111, 16'h0000, 1'b1, 1'b0, 0, 2);

        // Reset during a load-use stall returns everything to reset values.
        do_reset();
        set2(0, 1, 1, 2, 4, 1, 1, 0);
        set2(1, 1, 4, 5, 6, 1, 0, 0);
        step(21, 2, 4'b0000, 16'h0021, 1'b0, 1'b0, 0, 0);
        step(22, 2, 4'b0000, 16'h0023, 1'b0, 1'b1, 0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        step(23, 2, 4'b0011, 16'h0000, 1'b1, 1'b0, 0, 0);

        for (int i = 0; i < 10 && sbq.size() > 0; i++)
            @(negedge clk);
        if (sbq.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
